// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: parametrised multi-digit BCD up/down counter with programmable modulus, sync load and carry/borrow
// Ports: clk clock; rst sync active-high reset; en count enable; up direction (1 = up);
//        ld/ld_val synchronous BCD load; count registered BCD value; tc terminal-count level;
//        co/bo carry/borrow for cascading; ld_err one-cycle flag after an illegal load.
// Build option: define BCD_UPDOWN_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module bcd_updown_counter #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  ld,
   input  logic [4*DIGITS-1:0]   ld_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  co,
   output logic                  bo,
   output logic                  ld_err
);
   localparam int W = 4 * DIGITS;
   if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_params
      $error("bcd_updown_counter: DIGITS or MODULUS out of range");
   end
   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction
   localparam logic [W-1:0] TOP = to_bcd(MODULUS - 1);
   logic [W-1:0] inc, dec, step;
   logic [3:0]   d;
   logic         ld_ok, cy, bw, at_top, at_zero;
   int           val;
   always_comb begin
      val = 0;
      ld_ok = 1'b1;
      cy = 1'b1;
      bw = 1'b1;
      d = '0;
      inc = count;
      dec = count;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         ld_ok = ld_ok & (ld_val[4*i +: 4] <= 4'd9);
         val = val * 10 + int'(ld_val[4*i +: 4]);
      end
      ld_ok = ld_ok & (val < MODULUS);
      // ripple the decimal carry/borrow from digit 0 upwards
      for (int i = 0; i < DIGITS; i++) begin
         d = count[4*i +: 4];
         inc[4*i +: 4] = cy ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
         dec[4*i +: 4] = bw ? (d == 4'd0 ? 4'd9 : d - 4'd1) : d;
         cy = cy & (d == 4'd9);
         bw = bw & (d == 4'd0);
      end
   end
   assign at_top  = count == TOP;
   assign at_zero = count == '0;
   assign tc      = up ? at_top : at_zero;
   assign co      = en & up & at_top;
   assign bo      = en & ~up & at_zero;
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
   assign step = up ? (at_top ? TOP : inc) : (at_zero ? '0 : dec);
`else
   assign step = up ? (at_top ? '0 : inc) : (at_zero ? TOP : dec);
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         ld_err <= 1'b0;
      end else if (ld) begin
         count  <= ld_ok ? ld_val : '0;
         ld_err <= ~ld_ok;
      end else begin
         ld_err <= 1'b0;
         if (en) count <= step;
      end
   end
endmodule
